// File: rtl/sram_req_arbiter_pkg.sv
// sram_req_arbiter_pkg: shared encodings and request-bundle packing for the SRAM-like port arbiter.
`ifndef SRAM_REQ_BUS_WD
`define SRAM_REQ_BUS_WD 71
`endif
package sram_req_arbiter_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic RID_INST = 1'b0;
    localparam logic RID_DATA = 1'b1;
    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;
    function automatic logic [`SRAM_REQ_BUS_WD-1:0] pack_req(input logic wr, input logic [1:0] size,
                                                             input logic [31:0] addr, input logic [3:0] wstrb,
                                                             input logic [31:0] wdata);
        return {wr, size, addr, wstrb, wdata};
    endfunction
endpackage

// File: rtl/sram_id_fifo.sv
// sram_id_fifo: in-order FIFO of requester IDs for accepted-but-unanswered requests.
module sram_id_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    always_comb begin
        full = count_q == (PTR_W+1)'(DEPTH);
        empty = count_q == '0;
        head = mem_q[rd_ptr_q];
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between IF and MEM, routing in-order responses back to their issuer.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err
);
    arb_state_e state_q, state_d;
    logic owner_q, owner_d, err_q, err_d;
    logic grant_id, grant_req, push, pop, full, empty, head;
    logic [`SRAM_REQ_BUS_WD-1:0] m_bus;
    always_comb begin
        grant_id = (state_q == ST_LOCKED) ? owner_q : (d_req ? RID_DATA : RID_INST);
        grant_req = (grant_id == RID_DATA) ? d_req : i_req;
        m_req = grant_req && !full;
        m_bus = !grant_req ? '0 :
                (grant_id == RID_DATA) ? pack_req(d_wr, d_size, d_addr, d_wstrb, d_wdata)
                                       : pack_req(i_wr, i_size, i_addr, i_wstrb, i_wdata);
        push = m_req && m_addr_ok;
        pop = m_data_ok && !empty;
        i_addr_ok = push && grant_id == RID_INST;
        d_addr_ok = push && grant_id == RID_DATA;
        i_data_ok = pop && head == RID_INST;
        d_data_ok = pop && head == RID_DATA;
        i_rdata = i_data_ok ? m_rdata : '0;
        d_rdata = d_data_ok ? m_rdata : '0;
        state_d = state_q;
        owner_d = owner_q;
        err_d = err_q || (m_data_ok && empty);
        // A locked owner withdrawing its request is a protocol violation; release the lock.
        if (state_q == ST_LOCKED) begin
            state_d = (!grant_req || push) ? ST_IDLE : ST_LOCKED;
            err_d = err_d || !grant_req;
        end else if (m_req && !m_addr_ok) begin
            state_d = ST_LOCKED;
            owner_d = grant_id;
        end
    end
    assign {m_wr, m_size, m_addr, m_wstrb, m_wdata} = m_bus;
    assign err = err_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= RID_INST;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q <= err_d;
        end
    end
    sram_id_fifo #(.DEPTH(MAX_OUT), .PTR_W(PTR_W)) u_id_fifo (
        .clk(clk),
        .resetn(resetn),
        .push(push),
        .pop(pop),
        .din(grant_id),
        .full(full),
        .empty(empty),
        .head(head)
    );
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed scoreboard bench for the IF/MEM SRAM port arbiter.
module tb_sram_req_arbiter;
    logic clk, resetn;
    logic i_req, i_wr, d_req, d_wr;
    logic [1:0] i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_addr, m_wdata, i_rdata, d_rdata, m_rdata;
    logic [3:0] i_wstrb, d_wstrb, m_wstrb;
    logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic m_req, m_wr, m_addr_ok, m_data_ok, err;
    int tests = 0;
    int fails = 0;
    bit exp_q[$];

    sram_req_arbiter #(.MAX_OUT(4), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 0; i_wstrb = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 0; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic apply_reset();
        resetn = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_addr_ok", {i_addr_ok, d_addr_ok}, 0);
        chk("rst_data_ok", {i_data_ok, d_data_ok}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        tick();
        resetn = 1;
        exp_q.delete();
    endtask

    task automatic check_resp(input logic [31:0] data);
        bit id;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        id = exp_q.pop_front();
        chk("i_data_ok", i_data_ok, !id);
        chk("d_data_ok", d_data_ok, id);
        chk("i_rdata", i_rdata, id ? 32'h0 : data);
        chk("d_rdata", d_rdata, id ? data : 32'h0);
    endtask

    task automatic respond(input logic [31:0] data);
        m_data_ok = 1; m_rdata = data;
        @(negedge clk);
        check_resp(data);
        tick();
        m_data_ok = 0; m_rdata = 0;
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        #1;
        apply_reset();

        // data-only read
        d_req = 1; d_addr = 32'h1000; m_addr_ok = 1;
        @(negedge clk);
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h1000);
        chk("t1_d_addr_ok", d_addr_ok, 1);
        chk("t1_i_addr_ok", i_addr_ok, 0);
        exp_q.push_back(1);
        tick();
        d_req = 0; m_addr_ok = 0;
        @(negedge clk);
        chk("t1_no_ok", {d_addr_ok, d_data_ok, i_data_ok}, 0);
        tick();
        respond(32'hDEADBEEF);

        // simultaneous requests: data wins
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80; m_addr_ok = 1;
        @(negedge clk);
        chk("t2_d_first", d_addr_ok, 1);
        chk("t2_i_wait", i_addr_ok, 0);
        chk("t2_m_addr", m_addr, 32'h80);
        exp_q.push_back(1);
        tick();
        d_req = 0;
        @(negedge clk);
        chk("t2_i_second", i_addr_ok, 1);
        chk("t2_m_addr2", m_addr, 32'h40);
        exp_q.push_back(0);
        tick();
        i_req = 0; m_addr_ok = 0;
        respond(32'h11);
        respond(32'h22);

        // lock holds inst grant against a later data request
        i_req = 1; i_addr = 32'h2000; d_addr = 32'h3000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) d_req = 1;
            @(negedge clk);
            chk("t3_lock_addr", m_addr, 32'h2000);
            chk("t3_no_accept", {i_addr_ok, d_addr_ok}, 0);
            tick();
        end
        m_addr_ok = 1;
        @(negedge clk);
        chk("t3_i_accept", i_addr_ok, 1);
        chk("t3_d_wait", d_addr_ok, 0);
        exp_q.push_back(0);
        tick();
        i_req = 0;
        @(negedge clk);
        chk("t3_d_accept", d_addr_ok, 1);
        chk("t3_d_addr", m_addr, 32'h3000);
        exp_q.push_back(1);
        tick();
        d_req = 0; m_addr_ok = 0;
        respond(32'h33);
        respond(32'h44);

        // fill the FIFO, then push/pop in the full cycle
        d_req = 1; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            d_addr = 32'h100 + 32'(k * 4);
            @(negedge clk);
            chk("t4_fill_accept", d_addr_ok, 1);
            exp_q.push_back(1);
            tick();
        end
        d_addr = 32'h200;
        @(negedge clk);
        chk("t4_full_m_req", m_req, 0);
        chk("t4_full_addr_ok", d_addr_ok, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h500;
        @(negedge clk);
        chk("t4_full_pop_m_req", m_req, 0);
        check_resp(32'h500);
        tick();
        m_data_ok = 0;
        @(negedge clk);
        chk("t4_after_pop_m_req", m_req, 1);
        chk("t4_after_pop_accept", d_addr_ok, 1);
        exp_q.push_back(1);
        tick();
        d_req = 0; m_addr_ok = 0;
        for (int k = 0; k < 4; k++) respond(32'h600 + 32'(k));

        // response with nothing outstanding
        @(negedge clk);
        chk("t5_err_before", err, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h55;
        @(negedge clk);
        chk("t5_stray_data_ok", {i_data_ok, d_data_ok}, 0);
        chk("t5_stray_rdata", i_rdata | d_rdata, 0);
        tick();
        m_data_ok = 0;
        @(negedge clk);
        chk("t5_err_set", err, 1);
        tick();
        apply_reset();

        // alternating requests across pointer wrap
        for (int k = 0; k < 10; k++) begin
            bit id;
            id = k[0];
            if (id) begin d_req = 1; d_addr = 32'(k * 4); end
            else begin i_req = 1; i_addr = 32'(k * 4); end
            m_addr_ok = 1;
            @(negedge clk);
            chk("t6_i_addr_ok", i_addr_ok, !id);
            chk("t6_d_addr_ok", d_addr_ok, id);
            chk("t6_m_addr", m_addr, 32'(k * 4));
            exp_q.push_back(id);
            tick();
            i_req = 0; d_req = 0; m_addr_ok = 0;
            respond(32'hA0 + 32'(k));
        end

        // owner withdraws request while locked
        i_req = 1; i_addr = 32'h7000;
        @(negedge clk);
        chk("t7_lock_req", m_req, 1);
        tick();
        i_req = 0;
        @(negedge clk);
        chk("t7_drop_m_req", m_req, 0);
        tick();
        @(negedge clk);
        chk("t7_err", err, 1);
        tick();
        apply_reset();

        // reset mid-transaction drops outstanding tracking
        d_req = 1; d_addr = 32'h900; m_addr_ok = 1;
        @(negedge clk);
        chk("t8_accept", d_addr_ok, 1);
        tick();
        apply_reset();
        m_data_ok = 1; m_rdata = 32'h99;
        @(negedge clk);
        chk("t8_late_data_ok", {i_data_ok, d_data_ok}, 0);
        tick();
        m_data_ok = 0;
        @(negedge clk);
        chk("t8_late_err", err, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
